// File: rtl/exe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : exe_pkg
// Purpose  : Types and constants shared by the execution-result collector
//            and its helpers. The status bit positions (OVF_BIT, ERROR_BIT,
//            EVEN_BIT, SINGLE_BIT) are macros owned by macros.hv. They are
//            not duplicated here.
// Contents : STATUS_W - width of the per-result status word
//            status_t - status word type
// Revision : 1.0 - initial release
// ============================================================================
package exe_pkg;

    localparam int STATUS_W = 4;

    typedef logic [STATUS_W-1:0] status_t;

endpackage : exe_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Up-counter that stops at all-ones instead of wrapping.
//            A synchronous clear has priority over a same-cycle increment.
// Ports    : i_clk  - clock, rising edge
//            i_rst  - synchronous active-high reset
//            i_clr  - synchronous clear to zero
//            i_inc  - increment request
//            o_cnt  - current count (W bits)
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule : sat_counter
`default_nettype wire

// File: rtl/exe_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : exe_result_collector
// Purpose  : Captures every valid execution result and its status word.
//            Results are buffered in a first-word-fall-through FIFO and
//            offered downstream over a valid/ready handshake. The producer
//            cannot stall, so a result that arrives while the FIFO is full
//            and not popping is dropped. The drop is flagged in the sticky
//            o_drop output.
//            Optional macro EXE_STATUS_COUNTERS_EN builds saturating
//            counters for the error and overflow status bits of accepted
//            results. Without the macro these counter outputs are tied to 0.
// Ports    : i_clk, i_rst               - clock, sync active-high reset
//            i_valid, i_data, i_status  - result input from execution unit
//            o_valid, i_ready           - downstream handshake
//            o_data, o_status           - FIFO head entry
//            o_level, o_full, o_empty   - occupancy (registered state)
//            o_drop                     - sticky "result discarded"
//            i_clr                      - clears o_drop and counters
//            o_err_cnt, o_ovf_cnt       - status counters (macro-gated)
// Revision : 1.0 - initial release
// ============================================================================

// Default bit positions. A macros.hv seen earlier in the compile takes
// precedence.
`ifndef OVF_BIT
`define OVF_BIT 3
`endif
`ifndef ERROR_BIT
`define ERROR_BIT 2
`endif
`ifndef EVEN_BIT
`define EVEN_BIT 1
`endif
`ifndef SINGLE_BIT
`define SINGLE_BIT 0
`endif

module exe_result_collector
    import exe_pkg::*;
#(
    parameter int BITS  = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    input  logic [BITS-1:0]          i_data,
    input  status_t                  i_status,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [BITS-1:0]          o_data,
    output status_t                  o_status,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_drop,
    input  logic                     i_clr,
    output logic [CNT_W-1:0]         o_err_cnt,
    output logic [CNT_W-1:0]         o_ovf_cnt
);

    localparam int              c_aw    = $clog2(DEPTH);
    localparam int              c_ent_w = BITS + STATUS_W;
    localparam logic [c_aw:0]   c_depth = DEPTH[c_aw:0];

    logic [c_ent_w-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]    r_wr_ptr;
    logic [c_aw-1:0]    r_rd_ptr;
    logic [c_aw:0]      r_level;
    logic               r_drop;

    logic               w_pop;
    logic               w_push;
    logic               w_drop;

    // Status flags are derived only from registered occupancy.
    assign o_full  = (r_level == c_depth);
    assign o_empty = (r_level == '0);
    assign o_valid = !o_empty;
    assign o_level = r_level;

    assign w_pop  = o_valid & i_ready;
    // i_ready reaches the push enable only here. A full FIFO that is
    // popping this cycle can still accept a new result.
    assign w_push = i_valid & (!o_full | w_pop);
    assign w_drop = i_valid & o_full & !w_pop;

    // Storage has no enable-free bypass. It is reset so the head is never X.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= {i_data, i_status};
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // A clear discards any drop event in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_drop <= 1'b0;
        end else if (w_drop) begin
            r_drop <= 1'b1;
        end
    end

    assign o_drop   = r_drop;
    assign o_data   = r_mem[r_rd_ptr][c_ent_w-1:STATUS_W];
    assign o_status = r_mem[r_rd_ptr][STATUS_W-1:0];

`ifdef EXE_STATUS_COUNTERS_EN
    // Only accepted results are counted. Dropped results are excluded.
    logic w_err_inc;
    logic w_ovf_inc;

    assign w_err_inc = w_push & i_status[`ERROR_BIT];
    assign w_ovf_inc = w_push & i_status[`OVF_BIT];

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_clr),
        .i_inc (w_err_inc),
        .o_cnt (o_err_cnt)
    );

    sat_counter #(.W(CNT_W)) u_ovf_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_clr),
        .i_inc (w_ovf_inc),
        .o_cnt (o_ovf_cnt)
    );
`else
    assign o_err_cnt = '0;
    assign o_ovf_cnt = '0;
`endif

endmodule : exe_result_collector
`default_nettype wire

// File: tb/tb_exe_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_exe_result_collector
// Purpose  : Directed self-checking bench for exe_result_collector.
//            Configuration: BITS=8, DEPTH=4, CNT_W=2.
//            Expected counter values are forced to zero when
//            EXE_STATUS_COUNTERS_EN is undefined.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef OVF_BIT
`define OVF_BIT 3
`endif
`ifndef ERROR_BIT
`define ERROR_BIT 2
`endif

module tb_exe_result_collector;

    localparam int BITS  = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 2;

`ifdef EXE_STATUS_COUNTERS_EN
    localparam bit c_cnt_en = 1'b1;
`else
    localparam bit c_cnt_en = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             valid_in;
    logic [BITS-1:0]  data_in;
    logic [3:0]       status_in;
    logic             valid_out;
    logic             ready;
    logic [BITS-1:0]  data_out;
    logic [3:0]       status_out;
    logic [2:0]       level;
    logic             full;
    logic             empty;
    logic             drop;
    logic             clr;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] ovf_cnt;

    int total  = 0;
    int passed = 0;

    logic [3:0] c_err_st;
    logic [3:0] c_ovf_st;

    always #5 clk = ~clk;

    exe_result_collector #(.BITS(BITS), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_valid   (valid_in),
        .i_data    (data_in),
        .i_status  (status_in),
        .o_valid   (valid_out),
        .i_ready   (ready),
        .o_data    (data_out),
        .o_status  (status_out),
        .o_level   (level),
        .o_full    (full),
        .o_empty   (empty),
        .o_drop    (drop),
        .i_clr     (clr),
        .o_err_cnt (err_cnt),
        .o_ovf_cnt (ovf_cnt)
    );

    function automatic logic [CNT_W-1:0] exp_cnt(input int v);
        return c_cnt_en ? CNT_W'(v) : '0;
    endfunction

    // Advance one clock. Outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_in = 1'b1; data_in = 8'hAA; status_in = 4'hF;
        ready = 1'b0; clr = 1'b0;
        step(); step();
        rst = 1'b0; valid_in = 1'b0;
        step();
        total++; if (empty !== 1'b1) $display("FAIL reset_empty got=%b exp=1", empty); else passed++;
        total++; if (valid_out !== 1'b0) $display("FAIL reset_valid got=%b exp=0", valid_out); else passed++;
        total++; if (level !== 3'd0) $display("FAIL reset_level got=%0d exp=0", level); else passed++;
        total++; if (full !== 1'b0) $display("FAIL reset_full got=%b exp=0", full); else passed++;
        total++; if (data_out !== 8'h00) $display("FAIL reset_data got=%h exp=00", data_out); else passed++;
        total++; if (status_out !== 4'h0) $display("FAIL reset_status got=%h exp=0", status_out); else passed++;
        total++; if (drop !== 1'b0) $display("FAIL reset_drop got=%b exp=0", drop); else passed++;
        total++; if (err_cnt !== '0 || ovf_cnt !== '0)
            $display("FAIL reset_cnt got=%0d/%0d exp=0/0", err_cnt, ovf_cnt); else passed++;
    endtask

    task automatic test_fifo_order();
        logic [7:0] vals [3];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid_in = 1'b1; data_in = vals[i]; status_in = 4'(i + 1);
            step();
            total++; if (level !== 3'(i + 1))
                $display("FAIL order_level%0d got=%0d exp=%0d", i, level, i + 1); else passed++;
        end
        total++; if (data_out !== 8'h11) $display("FAIL order_head got=%h exp=11", data_out); else passed++;
        valid_in = 1'b0; ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++; if (data_out !== vals[i] || status_out !== 4'(i + 1))
                $display("FAIL order_pop%0d got=%h/%h exp=%h/%h", i, data_out, status_out, vals[i], 4'(i + 1));
            else passed++;
            step();
        end
        total++; if (empty !== 1'b1 || valid_out !== 1'b0)
            $display("FAIL order_empty got=%b/%b exp=1/0", empty, valid_out); else passed++;
        ready = 1'b0;
    endtask

    task automatic test_overflow();
        ready = 1'b0; status_in = 4'h0;
        for (int i = 1; i <= 5; i++) begin
            valid_in = 1'b1; data_in = 8'(i);
            step();
            if (i == 4) begin
                total++; if (full !== 1'b1) $display("FAIL ovf_full got=%b exp=1", full); else passed++;
                total++; if (drop !== 1'b0) $display("FAIL ovf_nodrop_yet got=%b exp=0", drop); else passed++;
            end
        end
        valid_in = 1'b0;
        total++; if (drop !== 1'b1) $display("FAIL ovf_drop got=%b exp=1", drop); else passed++;
        total++; if (level !== 3'd4) $display("FAIL ovf_level got=%0d exp=4", level); else passed++;
        total++; if (data_out !== 8'h01) $display("FAIL ovf_head got=%h exp=01", data_out); else passed++;
        clr = 1'b1;
        step();
        clr = 1'b0;
        total++; if (drop !== 1'b0) $display("FAIL ovf_clr got=%b exp=0", drop); else passed++;
        total++; if (level !== 3'd4) $display("FAIL ovf_clr_level got=%0d exp=4", level); else passed++;
    endtask

    // Starts from a full FIFO that holds 1..4.
    task automatic test_full_push_pop();
        logic [7:0] exp_q [4];
        exp_q[0] = 8'h02; exp_q[1] = 8'h03; exp_q[2] = 8'h04; exp_q[3] = 8'h55;
        valid_in = 1'b1; data_in = 8'h55; status_in = 4'h0; ready = 1'b1;
        step();
        valid_in = 1'b0; ready = 1'b0;
        total++; if (level !== 3'd4) $display("FAIL fpp_level got=%0d exp=4", level); else passed++;
        total++; if (drop !== 1'b0) $display("FAIL fpp_drop got=%b exp=0", drop); else passed++;
        total++; if (full !== 1'b1) $display("FAIL fpp_full got=%b exp=1", full); else passed++;
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (data_out !== exp_q[i])
                $display("FAIL fpp_drain%0d got=%h exp=%h", i, data_out, exp_q[i]); else passed++;
            step();
        end
        total++; if (empty !== 1'b1) $display("FAIL fpp_empty got=%b exp=1", empty); else passed++;
        ready = 1'b0;
    endtask

    task automatic test_counters();
        int exp_err [5];
        exp_err[0] = 1; exp_err[1] = 2; exp_err[2] = 3; exp_err[3] = 3; exp_err[4] = 3;
        ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            valid_in = 1'b1; data_in = 8'(8'h40 + i); status_in = c_err_st;
            step();
            total++; if (err_cnt !== exp_cnt(exp_err[i]))
                $display("FAIL cnt_err%0d got=%0d exp=%0d", i, err_cnt, exp_cnt(exp_err[i])); else passed++;
        end
        status_in = c_ovf_st;
        step();
        total++; if (ovf_cnt !== exp_cnt(1)) $display("FAIL cnt_ovf got=%0d exp=%0d", ovf_cnt, exp_cnt(1)); else passed++;
        total++; if (err_cnt !== exp_cnt(3)) $display("FAIL cnt_err_hold got=%0d exp=%0d", err_cnt, exp_cnt(3)); else passed++;
        status_in = c_err_st; clr = 1'b1;
        step();
        clr = 1'b0; valid_in = 1'b0;
        total++; if (err_cnt !== '0 || ovf_cnt !== '0)
            $display("FAIL cnt_clr got=%0d/%0d exp=0/0", err_cnt, ovf_cnt); else passed++;
        step(); step();
        total++; if (empty !== 1'b1) $display("FAIL cnt_drain got=%b exp=1", empty); else passed++;
        ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid_in = 1'b1; data_in = 8'(8'h70 + i); status_in = c_err_st;
            step();
        end
        total++; if (level !== 3'd3 || err_cnt !== exp_cnt(3))
            $display("FAIL rmid_pre got=%0d/%0d exp=3/%0d", level, err_cnt, exp_cnt(3)); else passed++;
        rst = 1'b1; valid_in = 1'b1; data_in = 8'h99;
        step();
        rst = 1'b0; valid_in = 1'b0;
        total++; if (level !== 3'd0 || empty !== 1'b1 || valid_out !== 1'b0)
            $display("FAIL rmid_occ got=%0d/%b/%b exp=0/1/0", level, empty, valid_out); else passed++;
        total++; if (err_cnt !== '0 || ovf_cnt !== '0)
            $display("FAIL rmid_cnt got=%0d/%0d exp=0/0", err_cnt, ovf_cnt); else passed++;
        total++; if (data_out !== 8'h00) $display("FAIL rmid_data got=%h exp=00", data_out); else passed++;
    endtask

    initial begin
        c_err_st = '0; c_err_st[`ERROR_BIT] = 1'b1;
        c_ovf_st = '0; c_ovf_st[`OVF_BIT]   = 1'b1;
        test_reset();
        test_fifo_order();
        test_overflow();
        test_full_push_pop();
        test_counters();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_exe_result_collector
`default_nettype wire
